prog_seq: RTL and testbench

Parametrised program sequencer: next generation of the program-counter/memory-address generator. Produces the instruction-memory address each step, selecting PC+1, an unconditional or flag-conditional branch target, a subroutine call target, or a return address popped from an internal return-address stack. It sits between the instruction register/decoder and the instruction memory address port, advancing only on the single-step/enable strobe.

---
 rtl/prog_seq_pkg.sv | 34 +++
 rtl/ret_stack.sv | 69 ++++++
 rtl/prog_seq.sv | 148 ++++++++++++++
 tb/tb_prog_seq.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_seq_pkg.sv
// ---------------------------------------------------------------------------
// prog_seq_pkg
// Shared definitions for the program sequencer and the instruction decoder
// that drives its op input.
//   op_e     : 3-bit sequencing opcode
//   cond_met : evaluates whether a jump-class opcode redirects to target
// ---------------------------------------------------------------------------
package prog_seq_pkg;

    typedef enum logic [2:0] {
        OP_NXT  = 3'd0,
        OP_JMP  = 3'd1,
        OP_JZ   = 3'd2,
        OP_JNZ  = 3'd3,
        OP_JC   = 3'd4,
        OP_JNC  = 3'd5,
        OP_CALL = 3'd6,
        OP_RET  = 3'd7
    } op_e;

    // True when a jump-class opcode takes its target. CALL/RET depend on the
    // return stack rather than the flags, so they are handled by the caller.
    function automatic logic cond_met(input op_e op, input logic zero, input logic carry);
        case (op)
            OP_JMP:  return 1'b1;
            OP_JZ:   return zero;
            OP_JNZ:  return !zero;
            OP_JC:   return carry;
            OP_JNC:  return !carry;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ret_stack.sv
// ---------------------------------------------------------------------------
// ret_stack
// Return-address LIFO for subroutine calls.
//   clk, rst : clock, asynchronous active-low reset
//   push     : write din on top (ignored when full)
//   pop      : discard top entry (ignored when empty)
//   din      : return address to push
//   dout     : current top entry (undefined when empty)
//   count    : occupancy 0..DEPTH
//   full     : count == DEPTH
//   empty    : count == 0
// ---------------------------------------------------------------------------
module ret_stack
    import prog_seq_pkg::*;
#(
    parameter int AW    = 5,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] din,
    output logic [AW-1:0] dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] mem [DEPTH];
    logic [CW-1:0] cnt;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] top_idx;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty && !do_push;
    assign wr_idx  = IW'(cnt);
    assign top_idx = IW'(cnt - CW'(1));
    assign dout    = mem[top_idx];
    assign count   = cnt;

    // NOTE: the entry array has no reset; an entry is only ever read after it
    // has been pushed, and count (which is reset) decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (do_push) begin
            cnt <= cnt + CW'(1);
        end else if (do_pop) begin
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/prog_seq.sv
// ---------------------------------------------------------------------------
// prog_seq
// Program sequencer: generates the instruction-memory address each step.
//   clk, rst : clock, asynchronous active-low reset
//   step     : advance enable; all state holds when low
//   ld       : direct PC load from target, overrides op
//   op       : sequencing opcode (prog_seq_pkg::op_e)
//   target   : branch/call/load address
//   zero     : ALU zero flag, carry : ALU carry flag
//   clr_err  : clears sticky stk_ovf/stk_unf
//   pc       : current memory address (registered)
//   taken    : 1 for the cycle after a step that redirected the PC
//   sp       : return-stack occupancy
//   stk_ovf  : sticky, CALL attempted with stack full
//   stk_unf  : sticky, RET attempted with stack empty
// ---------------------------------------------------------------------------
module prog_seq
    import prog_seq_pkg::*;
#(
    parameter int          AW      = 5,
    parameter int          DEPTH   = 4,
    parameter logic [AW-1:0] RST_VEC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       step,
    input  logic                       ld,
    input  logic [2:0]                 op,
    input  logic [AW-1:0]              target,
    input  logic                       zero,
    input  logic                       carry,
    input  logic                       clr_err,
    output logic [AW-1:0]              pc,
    output logic                       taken,
    output logic [$clog2(DEPTH+1)-1:0] sp,
    output logic                       stk_ovf,
    output logic                       stk_unf
);

    localparam int SW = $clog2(DEPTH + 1);

    op_e           op_c;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] pc_nxt;
    logic          redirect;
    logic          push;
    logic          pop;
    logic          ovf_evt;
    logic          unf_evt;
    logic [AW-1:0] stk_top;
    logic [SW-1:0] stk_cnt;
    logic          stk_full;
    logic          stk_empty;

    assign op_c = op_e'(op);
    // Natural AW-bit overflow gives the required wrap from all-ones to zero,
    // for both the sequential PC and the pushed return address.
    assign pc_inc = pc + AW'(1);

    ret_stack #(
        .AW    (AW),
        .DEPTH (DEPTH),
        .CW    (SW)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .dout  (stk_top),
        .count (stk_cnt),
        .full  (stk_full),
        .empty (stk_empty)
    );

    // NOTE: every signal is given a default before the branches so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        pc_nxt   = pc;
        redirect = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        ovf_evt  = 1'b0;
        unf_evt  = 1'b0;
        if (step) begin
            pc_nxt = pc_inc;
            if (ld) begin
                pc_nxt   = target;
                redirect = 1'b1;
            end else begin
                case (op_c)
                    OP_CALL: begin
                        if (!stk_full) begin
                            push     = 1'b1;
                            pc_nxt   = target;
                            redirect = 1'b1;
                        end else begin
                            ovf_evt = 1'b1;
                        end
                    end
                    OP_RET: begin
                        if (!stk_empty) begin
                            pop      = 1'b1;
                            pc_nxt   = stk_top;
                            redirect = 1'b1;
                        end else begin
                            unf_evt = 1'b1;
                        end
                    end
                    default: begin
                        // A taken branch counts as a redirect even when the
                        // target happens to equal PC+1.
                        if (cond_met(op_c, zero, carry)) begin
                            pc_nxt   = target;
                            redirect = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= RST_VEC;
            taken   <= 1'b0;
            stk_ovf <= 1'b0;
            stk_unf <= 1'b0;
        end else begin
            pc    <= pc_nxt;
            taken <= redirect;
            // A new error event outranks a simultaneous clear.
            if (ovf_evt) begin
                stk_ovf <= 1'b1;
            end else if (clr_err) begin
                stk_ovf <= 1'b0;
            end
            if (unf_evt) begin
                stk_unf <= 1'b1;
            end else if (clr_err) begin
                stk_unf <= 1'b0;
            end
        end
    end

    assign sp = stk_cnt;

endmodule

// File: tb/tb_prog_seq.sv
// ---------------------------------------------------------------------------
// tb_prog_seq
// Directed bench for prog_seq (AW=5, DEPTH=4, RST_VEC=0). Each stepped cycle
// pushes the model's expected outputs to a scoreboard queue; the entry is
// popped and compared once the DUT edge has happened.
// ---------------------------------------------------------------------------
module tb_prog_seq;
    import prog_seq_pkg::*;

    localparam int AW    = 5;
    localparam int DEPTH = 4;
    localparam int SW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst;
    logic          step;
    logic          ld;
    logic [2:0]    op;
    logic [AW-1:0] target;
    logic          zero;
    logic          carry;
    logic          clr_err;
    logic [AW-1:0] pc;
    logic          taken;
    logic [SW-1:0] sp;
    logic          stk_ovf;
    logic          stk_unf;

    prog_seq #(
        .AW      (AW),
        .DEPTH   (DEPTH),
        .RST_VEC (5'd0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .step    (step),
        .ld      (ld),
        .op      (op),
        .target  (target),
        .zero    (zero),
        .carry   (carry),
        .clr_err (clr_err),
        .pc      (pc),
        .taken   (taken),
        .sp      (sp),
        .stk_ovf (stk_ovf),
        .stk_unf (stk_unf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string         tag;
        logic [AW-1:0] pc;
        logic          taken;
        logic [SW-1:0] sp;
        logic          ovf;
        logic          unf;
    } exp_t;

    exp_t sb[$];

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_stk [DEPTH];
    int            m_sp;
    logic          m_ovf;
    logic          m_unf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc  = '0;
        m_sp  = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // Drive one cycle, predict its result, then compare after the edge.
    task automatic cyc(input string tag, input logic s, input logic l, input logic [2:0] o,
                       input logic [AW-1:0] t, input logic z, input logic c, input logic ce);
        exp_t          e;
        logic          tk;
        logic          set_o;
        logic          set_u;
        logic [AW-1:0] inc;
        step = s; ld = l; op = o; target = t; zero = z; carry = c; clr_err = ce;
        tk    = 1'b0;
        set_o = 1'b0;
        set_u = 1'b0;
        inc   = m_pc + 5'd1;
        if (s) begin
            if (l) begin
                m_pc = t; tk = 1'b1;
            end else begin
                case (o)
                    3'd1: begin m_pc = t; tk = 1'b1; end
                    3'd2: if (z)  begin m_pc = t; tk = 1'b1; end else m_pc = inc;
                    3'd3: if (!z) begin m_pc = t; tk = 1'b1; end else m_pc = inc;
                    3'd4: if (c)  begin m_pc = t; tk = 1'b1; end else m_pc = inc;
                    3'd5: if (!c) begin m_pc = t; tk = 1'b1; end else m_pc = inc;
                    3'd6: if (m_sp < DEPTH) begin
                              m_stk[m_sp] = inc; m_sp++; m_pc = t; tk = 1'b1;
                          end else begin
                              m_pc = inc; set_o = 1'b1;
                          end
                    3'd7: if (m_sp > 0) begin
                              m_sp--; m_pc = m_stk[m_sp]; tk = 1'b1;
                          end else begin
                              m_pc = inc; set_u = 1'b1;
                          end
                    default: m_pc = inc;
                endcase
            end
        end
        if (ce) begin m_ovf = 1'b0; m_unf = 1'b0; end
        if (set_o) m_ovf = 1'b1;
        if (set_u) m_unf = 1'b1;
        e.tag = tag; e.pc = m_pc; e.taken = tk; e.sp = SW'(m_sp); e.ovf = m_ovf; e.unf = m_unf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({e.tag, ".pc"},    32'(pc),      32'(e.pc));
        check({e.tag, ".taken"}, 32'(taken),   32'(e.taken));
        check({e.tag, ".sp"},    32'(sp),      32'(e.sp));
        check({e.tag, ".ovf"},   32'(stk_ovf), 32'(e.ovf));
        check({e.tag, ".unf"},   32'(stk_unf), 32'(e.unf));
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".pc"},    32'(pc),      32'd0);
        check({tag, ".taken"}, 32'(taken),   32'd0);
        check({tag, ".sp"},    32'(sp),      32'd0);
        check({tag, ".ovf"},   32'(stk_ovf), 32'd0);
        check({tag, ".unf"},   32'(stk_unf), 32'd0);
    endtask

    logic [2:0] cond_ops [4];
    logic       cond_z0  [4];
    logic       cond_c0  [4];

    initial begin
        rst = 1'b0; step = 1'b0; ld = 1'b0; op = '0; target = '0;
        zero = 1'b0; carry = 1'b0; clr_err = 1'b0;
        model_reset();
        #12;
        check_reset("reset");
        @(posedge clk);
        #1 rst = 1'b1;

        // Sequential stepping with wrap at 31 -> 0
        for (int i = 0; i < 33; i++) cyc("nxt", 1, 0, OP_NXT, 5'd0, 0, 0, 0);
        check("nxt_wrap_final_pc", 32'(pc), 32'd1);

        // Conditional branches at pc=4, target=20: first the not-taken flag
        // value, then the taken one.
        cond_ops[0] = OP_JZ;  cond_z0[0] = 1'b0; cond_c0[0] = 1'b0;
        cond_ops[1] = OP_JNZ; cond_z0[1] = 1'b1; cond_c0[1] = 1'b0;
        cond_ops[2] = OP_JC;  cond_z0[2] = 1'b0; cond_c0[2] = 1'b0;
        cond_ops[3] = OP_JNC; cond_z0[3] = 1'b0; cond_c0[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc("ld4", 1, 1, OP_NXT, 5'd4, 0, 0, 0);
            cyc("cond_nt", 1, 0, cond_ops[i], 5'd20, cond_z0[i], cond_c0[i], 0);
            check("cond_nt_pc", 32'(pc), 32'd5);
            check("cond_nt_taken", 32'(taken), 32'd0);
            cyc("ld4", 1, 1, OP_NXT, 5'd4, 0, 0, 0);
            cyc("cond_t", 1, 0, cond_ops[i], 5'd20, !cond_z0[i], !cond_c0[i], 0);
            check("cond_t_pc", 32'(pc), 32'd20);
            check("cond_t_taken", 32'(taken), 32'd1);
        end
        // Taken branch whose target equals PC+1 still reports taken
        cyc("ld4", 1, 1, OP_NXT, 5'd4, 0, 0, 0);
        cyc("jz_to_inc", 1, 0, OP_JZ, 5'd5, 1, 0, 0);
        check("jz_to_inc_taken", 32'(taken), 32'd1);

        // Step gating
        for (int i = 0; i < 10; i++) cyc("gate", 0, 0, OP_JMP, 5'd9, 1, 1, 0);
        check("gate_pc", 32'(pc), 32'd5);

        // Nested calls from pc 1,11,21,31
        cyc("ld1", 1, 1, OP_NXT, 5'd1, 0, 0, 0);
        cyc("call10", 1, 0, OP_CALL, 5'd10, 0, 0, 0);
        cyc("nxt", 1, 0, OP_NXT, 5'd0, 0, 0, 0);
        cyc("call20", 1, 0, OP_CALL, 5'd20, 0, 0, 0);
        cyc("nxt", 1, 0, OP_NXT, 5'd0, 0, 0, 0);
        cyc("call30", 1, 0, OP_CALL, 5'd30, 0, 0, 0);
        cyc("nxt", 1, 0, OP_NXT, 5'd0, 0, 0, 0);
        cyc("call3", 1, 0, OP_CALL, 5'd3, 0, 0, 0);
        check("calls_sp", 32'(sp), 32'd4);
        cyc("call_full", 1, 0, OP_CALL, 5'd17, 0, 0, 0);
        check("call_full_pc", 32'(pc), 32'd4);
        check("call_full_ovf", 32'(stk_ovf), 32'd1);
        check("call_full_sp", 32'(sp), 32'd4);
        cyc("ret_a", 1, 0, OP_RET, 5'd0, 0, 0, 0);
        check("ret_a_pc", 32'(pc), 32'd0);
        cyc("ret_b", 1, 0, OP_RET, 5'd0, 0, 0, 0);
        check("ret_b_pc", 32'(pc), 32'd22);
        cyc("ret_c", 1, 0, OP_RET, 5'd0, 0, 0, 0);
        check("ret_c_pc", 32'(pc), 32'd12);
        cyc("ret_d", 1, 0, OP_RET, 5'd0, 0, 0, 0);
        check("ret_d_pc", 32'(pc), 32'd2);
        check("ret_d_sp", 32'(sp), 32'd0);
        cyc("clr_ovf", 0, 0, OP_NXT, 5'd0, 0, 0, 1);
        check("clr_ovf_flag", 32'(stk_ovf), 32'd0);

        // Underflow and flag precedence
        cyc("ld7", 1, 1, OP_NXT, 5'd7, 0, 0, 0);
        cyc("ret_unf", 1, 0, OP_RET, 5'd0, 0, 0, 0);
        check("ret_unf_pc", 32'(pc), 32'd8);
        check("ret_unf_flag", 32'(stk_unf), 32'd1);
        cyc("ret_unf_clr", 1, 0, OP_RET, 5'd0, 0, 0, 1);
        check("set_beats_clr", 32'(stk_unf), 32'd1);
        cyc("clr_alone", 0, 0, OP_NXT, 5'd0, 0, 0, 1);
        check("clr_alone_flag", 32'(stk_unf), 32'd0);

        // ld overrides RET and leaves the stack alone
        cyc("ld0", 1, 1, OP_NXT, 5'd0, 0, 0, 0);
        cyc("call5", 1, 0, OP_CALL, 5'd5, 0, 0, 0);
        cyc("call6", 1, 0, OP_CALL, 5'd6, 0, 0, 0);
        cyc("ld_ret", 1, 1, OP_RET, 5'd13, 0, 0, 0);
        check("ld_ret_pc", 32'(pc), 32'd13);
        check("ld_ret_sp", 32'(sp), 32'd2);

        // Asynchronous reset in the middle of a cycle
        cyc("nxt", 1, 0, OP_NXT, 5'd0, 0, 0, 0);
        #3 rst = 1'b0;
        #1;
        check_reset("async_reset");
        model_reset();
        step = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        cyc("ret_after_rst", 1, 0, OP_RET, 5'd0, 0, 0, 0);
        check("ret_after_rst_unf", 32'(stk_unf), 32'd1);
        check("ret_after_rst_pc", 32'(pc), 32'd1);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
